axis_sample_source: RTL

//  AXI-Stream master that generates 8-bit test waveforms and feeds DSP filter sinks (s_data/s_valid/s_ready).

---
 rtl/axis_src_pkg.sv | 35 +++
 rtl/axis_sample_source_lfsr16.sv | 22 ++
 rtl/axis_sample_source.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/axis_src_pkg.sv
// Shared types and helpers for the axis_sample_source test-waveform generator.
package axis_src_pkg;

   typedef enum logic [1:0] {
      CONST  = 2'd0,
      RAMP   = 2'd1,
      SQUARE = 2'd2,
      STEP   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Unsigned add clamped to maxv.
   function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                           input int unsigned maxv);
      int unsigned s;
      s = a + b;
      return (s > maxv) ? maxv : s;
   endfunction

   // Unsigned subtract clamped at zero.
   function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
      return (b > a) ? 32'd0 : a - b;
   endfunction

   // One step of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR (shift toward MSB).
   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

endpackage

// File: rtl/axis_sample_source_lfsr16.sv
// 16-bit Fibonacci LFSR used as the noise source; reloads its seed on load.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] q
);
   import axis_src_pkg::*;

   // Seed on reset or load, otherwise step once per advance.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         q <= SEED;
      end else if (advance) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/axis_sample_source.sv
// AXI-Stream test-waveform source: emits a programmed number of 8-bit samples
// (CONST/RAMP/SQUARE/STEP) per run under backpressure, with busy/done status.
// Build option AXIS_SRC_NOISE_EN adds saturating LFSR noise to every sample.
//
// state | meaning
// IDLE  | waiting for start; config latched on start
// RUN   | m_valid high, one sample per handshake
// DONE  | single cycle with done=1, start ignored
module axis_sample_source #(
   parameter int DATA_W   = 8,
   parameter int LEN_W    = 16,
   parameter int HALF_PER = 4
`ifdef AXIS_SRC_NOISE_EN
   ,
   parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
   parameter logic [DATA_W-1:0] NOISE_MASK = 8'h07
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] level,
   input  logic [DATA_W-1:0] amp,
   input  logic [LEN_W-1:0]  length,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
);
   import axis_src_pkg::*;

   localparam int unsigned DMAX = (2 ** DATA_W) - 1;

   state_e            state;
   mode_e             mode_r;
   logic [DATA_W-1:0] level_r, amp_r;
   logic [LEN_W-1:0]  len_r, idx;
   logic              handshake, last_beat, start_ok;
   logic [DATA_W-1:0] first_sample, next_sample;

   function automatic logic [DATA_W-1:0] wave(input mode_e m, input logic [DATA_W-1:0] lv,
                                              input logic [DATA_W-1:0] am,
                                              input logic [LEN_W-1:0] len,
                                              input logic [LEN_W-1:0] k);
      logic [LEN_W-1:0]  half_cnt;
      logic [DATA_W-1:0] hi, lo, res;
      hi       = DATA_W'(sat_add(32'(lv), 32'(am), DMAX));
      lo       = DATA_W'(sat_sub(32'(lv), 32'(am)));
      half_cnt = k / LEN_W'(HALF_PER);
      case (m)
         CONST:   res = lv;
         RAMP:    res = lv + k[DATA_W-1:0];
         SQUARE:  res = half_cnt[0] ? lo : hi;
         STEP:    res = (k < (len >> 1)) ? lv : hi;
         default: res = lv;
      endcase
      return res;
   endfunction

   assign handshake = m_valid && m_ready;
   assign last_beat = handshake && (idx == len_r - LEN_W'(1));
   assign start_ok  = start && (state == IDLE);

`ifdef AXIS_SRC_NOISE_EN
   logic [15:0] lfsr_q;

   function automatic logic [DATA_W-1:0] add_noise(input logic [DATA_W-1:0] s,
                                                   input logic [15:0] r);
      logic [DATA_W-1:0] mag;
      mag = r[DATA_W-1:0] & NOISE_MASK;
      return r[DATA_W] ? DATA_W'(sat_sub(32'(s), 32'(mag)))
                       : DATA_W'(sat_add(32'(s), 32'(mag), DMAX));
   endfunction

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (start_ok),
      .advance (handshake),
      .q       (lfsr_q)
   );
`endif

   // Sample for beat 0 of a new run, and the preload for the beat after idx.
   always_comb begin
      first_sample = wave(mode_e'(mode), level, amp, length, '0);
      next_sample  = wave(mode_r, level_r, amp_r, len_r, idx + LEN_W'(1));
`ifdef AXIS_SRC_NOISE_EN
      first_sample = add_noise(first_sample, LFSR_SEED);
      next_sample  = add_noise(next_sample, lfsr_next(lfsr_q));
`endif
   end

   // Run sequencing with registered stream and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         m_valid <= 1'b0;
         m_data  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         idx     <= '0;
         mode_r  <= CONST;
         level_r <= '0;
         amp_r   <= '0;
         len_r   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start_ok) begin
                  mode_r  <= mode_e'(mode);
                  level_r <= level;
                  amp_r   <= amp;
                  len_r   <= length;
                  idx     <= '0;
                  if (length != '0) begin
                     state   <= RUN;
                     m_valid <= 1'b1;
                     busy    <= 1'b1;
                     m_data  <= first_sample;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (last_beat) begin
                  state   <= DONE;
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (handshake) begin
                  idx    <= idx + LEN_W'(1);
                  m_data <= next_sample;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
